pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
Hazard and forwarding controller for the 5-stage integer pipeline (fetch, decode, execute, memory, writeback). It shadows the destination register of every in-flight instruction and detects read-after-write hazards against the instruction in decode. It issues registered forwarding selects for the execute-stage operand muxes, and a stall/bubble when a load result is not yet available. It also handles a flush request that squashes the decode-stage instruction.

Parameters:
ADDR_W, 5, register address width; address 0 is hardwired zero and never hazards.
FWD_W, 2, forwarding-select width.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
dec_rs  input  ADDR_W  decode source address 1
dec_rt  input  ADDR_W  decode source address 2
dec_uses_rs  input  1  decode instruction reads rs
dec_uses_rt  input  1  decode instruction reads rt
dec_dest  input  ADDR_W  decode destination address
dec_writes  input  1  decode instruction writes dest
dec_is_load  input  1  decode instruction is a load (result ready at end of memory stage)
flush  input  1  squash instruction currently in decode
stall  output  1  hold PC and fetch/decode register, inject bubble into execute
ex_fwd_sel_1  output  FWD_W  execute operand 1 source
ex_fwd_sel_2  output  FWD_W  execute operand 2 source
ex_valid  output  1  instruction in execute is valid (gates downstream write enable)

Behaviour:
- Reset:
  - stall=0, ex_fwd_sel_1=ex_fwd_sel_2=0, ex_valid=0.
  - All shadow entries (EX, MEM, WB) are invalid.
- Shadow pipe: three entries {dest, writes, is_load}, advanced every cycle. Each entry is valid only if writes=1 and dest!=0.
  - EX entry loads from decode inputs, or a bubble when stall|flush.
  - MEM entry loads from EX.
  - WB entry loads from MEM.
- Forward select encoding:
  - 0 = register-file value.
  - 1 = execute/memory pipeline register.
  - 2 = memory/writeback pipeline register.
  - 3 = value captured from the writeback bus during decode.
- Select priority per operand, evaluated in decode against the older instructions and registered into execute on the next edge:
  - match with EX entry -> 1;
  - else MEM entry -> 2;
  - else WB entry -> 3;
  - else 0.
  - No match when the uses_* bit is 0 or the address is 0.
- Load-use hazard: EX entry is_load and valid, and dest matches a used source -> stall=1, combinational in the same cycle.
  - Next edge: bubble enters execute (ex_valid=0, selects 0) and decode holds.
  - The following cycle re-evaluates; the load is now in MEM, so select=2 and stall=0.
  - Stall lasts exactly 1 cycle per load-use pair.
- Two loads in a row, both consumed: independent single-cycle stalls.
- Selects and ex_valid are registered: latency decode -> execute is 1 cycle. While stalled, execute receives a bubble.
- flush: the decode instruction is converted to a bubble (ex_valid=0 next cycle, no hazard recorded).
  - flush overrides stall: stall=0 when flush=1.
- reset mid-operation: all entries are invalidated on the same edge; no residual forwarding.
- Both operands may match different stages simultaneously; each is resolved independently.

Optional Feature:
PERF_COUNTERS_EN:
- Defined: adds outputs stall_count[31:0] and flush_count[31:0].
  - Each increments on every cycle stall (respectively flush) is 1.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the ports and counters are absent; core behaviour is identical.

Decomposition:
- Package pipeline_pkg:
  - ADDR_W.
  - fwd_sel_t encoding constants FWD_REGFILE=0, FWD_EX_MEM=1, FWD_MEM_WB=2, FWD_WB_BYPASS=3.
  - struct shadow_entry_t {dest, writes, is_load}.
- Sub-module hazard_match: combinational comparison of one source address against three shadow entries, returning select and load-hit. Instantiated once per operand.

Test Plan:
- add r3,r1,r2 then add r4,r3,r3 -> second instruction in execute: sel_1=sel_2=1, stall never 1.
- Producer r5 followed by 1 independent instruction, then consumer of r5 -> sel=2; with 2 independent instructions in between -> sel=3; with 3 -> sel=0.
- load r6 then add r7,r6,r1 -> stall=1 for exactly 1 cycle, bubble with ex_valid=0, then add in execute with sel_1=2.
- Producer with dest=r0 followed by consumer of r0 -> sel=0, no stall.
- flush asserted during a load-use stall -> stall=0 that cycle, ex_valid=0 next cycle, no later forwarding from the squashed dest.
- reset asserted with 3 valid producers in flight, then a consumer of their dests -> sel=0, ex_valid=0 after reset; with PERF_COUNTERS_EN, counters read 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the integer pipeline hazard/forwarding logic: register
// address width, forwarding-select encoding and the shadow-pipe entry layout.
package pipeline_pkg;

    // Register address width; register 0 is hardwired zero.
    localparam int ADDR_W = 5;
    // Width of the execute-stage operand mux select.
    localparam int FWD_W  = 2;

    // Where an execute-stage operand is taken from.
    typedef enum logic [FWD_W-1:0] {
        FWD_REGFILE   = 2'd0,  // register-file read
        FWD_EX_MEM    = 2'd1,  // execute/memory pipeline register
        FWD_MEM_WB    = 2'd2,  // memory/writeback pipeline register
        FWD_WB_BYPASS = 2'd3   // writeback bus value captured during decode
    } fwd_sel_t;

    // Destination bookkeeping for one in-flight instruction.
    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic              writes;
        logic              is_load;
    } shadow_entry_t;

    // True when the entry produces a real register that src is reading.
    function automatic logic entry_hit(input shadow_entry_t entry,
                                       input logic [ADDR_W-1:0] src);
        return entry.writes && (entry.dest != '0) && (entry.dest == src);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one decode-stage source address against the EX, MEM and WB shadow
// entries and returns the forwarding select (youngest producer wins) plus a
// flag when the youngest producer is a load still in execute.
module hazard_match
    import pipeline_pkg::*;
(
    input  logic [ADDR_W-1:0] src,
    input  logic              uses,
    input  shadow_entry_t     ex_entry,
    input  shadow_entry_t     mem_entry,
    input  shadow_entry_t     wb_entry,
    output fwd_sel_t          sel,
    output logic              load_hit
);

    // Only the execute entry can still be waiting on memory; the older
    // entries' load flags are irrelevant here.
    logic unused_load_bits;
    assign unused_load_bits = mem_entry.is_load ^ wb_entry.is_load;

    // Priority select: the youngest matching producer supplies the operand.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs (no latch).
        sel      = FWD_REGFILE;
        load_hit = 1'b0;
        if (uses && (src != '0)) begin
            if (entry_hit(ex_entry, src)) begin
                sel      = FWD_EX_MEM;
                load_hit = ex_entry.is_load;
            end else if (entry_hit(mem_entry, src)) begin
                sel = FWD_MEM_WB;
            end else if (entry_hit(wb_entry, src)) begin
                sel = FWD_WB_BYPASS;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard and forwarding controller for the 5-stage integer pipeline.
// Shadows the destination of every in-flight instruction (EX, MEM, WB),
// registers per-operand forwarding selects into execute, raises a one-cycle
// load-use stall and squashes decode on flush.
// Optional build macro PERF_COUNTERS_EN adds saturating stall/flush counters.
module pipeline_hazard_controller
    import pipeline_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] dec_rs,
    input  logic [ADDR_W-1:0] dec_rt,
    input  logic              dec_uses_rs,
    input  logic              dec_uses_rt,
    input  logic [ADDR_W-1:0] dec_dest,
    input  logic              dec_writes,
    input  logic              dec_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [FWD_W-1:0]  ex_fwd_sel_1,
    output logic [FWD_W-1:0]  ex_fwd_sel_2,
    output logic              ex_valid
`ifdef PERF_COUNTERS_EN
    ,
    output logic [31:0]       stall_count,
    output logic [31:0]       flush_count
`endif
);

    shadow_entry_t ex_q;
    shadow_entry_t mem_q;
    shadow_entry_t wb_q;

    fwd_sel_t sel_1;
    fwd_sel_t sel_2;
    logic     load_hit_1;
    logic     load_hit_2;
    logic     bubble;

    hazard_match u_match_1 (
        .src       (dec_rs),
        .uses      (dec_uses_rs),
        .ex_entry  (ex_q),
        .mem_entry (mem_q),
        .wb_entry  (wb_q),
        .sel       (sel_1),
        .load_hit  (load_hit_1)
    );

    hazard_match u_match_2 (
        .src       (dec_rt),
        .uses      (dec_uses_rt),
        .ex_entry  (ex_q),
        .mem_entry (mem_q),
        .wb_entry  (wb_q),
        .sel       (sel_2),
        .load_hit  (load_hit_2)
    );

    // A squashed instruction can never stall; reset also forces it low.
    assign stall  = (load_hit_1 | load_hit_2) & ~flush & ~reset;
    assign bubble = stall | flush;

    // Advance the shadow pipe and register the execute-stage controls.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the shadow entries are cleared on reset, not just the
            // outputs, so nothing in flight can be forwarded afterwards.
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            ex_fwd_sel_1 <= FWD_REGFILE;
            ex_fwd_sel_2 <= FWD_REGFILE;
            ex_valid     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every stage samples the pre-edge values.
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (bubble) begin
                ex_q         <= '0;
                ex_fwd_sel_1 <= FWD_REGFILE;
                ex_fwd_sel_2 <= FWD_REGFILE;
                ex_valid     <= 1'b0;
            end else begin
                ex_q         <= '{dest: dec_dest, writes: dec_writes, is_load: dec_is_load};
                ex_fwd_sel_1 <= sel_1;
                ex_fwd_sel_2 <= sel_2;
                ex_valid     <= 1'b1;
            end
        end
    end

`ifdef PERF_COUNTERS_EN
    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (flush && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios with
// literal expectations, then randomized traffic compared every cycle against
// a model that tracks the age of the youngest producer of each source.
`timescale 1ns/1ps
module tb_pipeline_hazard_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] dec_rs = '0;
    logic [4:0] dec_rt = '0;
    logic       dec_uses_rs = 1'b0;
    logic       dec_uses_rt = 1'b0;
    logic [4:0] dec_dest = '0;
    logic       dec_writes = 1'b0;
    logic       dec_is_load = 1'b0;
    logic       flush = 1'b0;
    logic       stall;
    logic [1:0] ex_fwd_sel_1;
    logic [1:0] ex_fwd_sel_2;
    logic       ex_valid;
`ifdef PERF_COUNTERS_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    pipeline_hazard_controller dut (
        .clock        (clock),
        .reset        (reset),
        .dec_rs       (dec_rs),
        .dec_rt       (dec_rt),
        .dec_uses_rs  (dec_uses_rs),
        .dec_uses_rt  (dec_uses_rt),
        .dec_dest     (dec_dest),
        .dec_writes   (dec_writes),
        .dec_is_load  (dec_is_load),
        .flush        (flush),
        .stall        (stall),
        .ex_fwd_sel_1 (ex_fwd_sel_1),
        .ex_fwd_sel_2 (ex_fwd_sel_2),
        .ex_valid     (ex_valid)
`ifdef PERF_COUNTERS_EN
        ,
        .stall_count  (stall_count),
        .flush_count  (flush_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // older[0] is the instruction now in execute, older[1] in memory,
    // older[2] in writeback; bubbles are entries that write nothing.
    typedef struct {
        logic [4:0] dest;
        logic       writes;
        logic       is_load;
    } m_entry_t;

    m_entry_t    older[$];
    logic [1:0]  m_sel1 = '0;
    logic [1:0]  m_sel2 = '0;
    logic        m_valid = 1'b0;
    logic        m_ready = 1'b0;
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_flush_cnt = '0;

    // Age of the youngest in-flight producer of src (3 = none).
    function automatic int age_of(input logic [4:0] src, input logic use_it);
        if (!use_it || src == 5'd0) return 3;
        for (int i = 0; i < older.size() && i < 3; i++) begin
            if (older[i].writes && older[i].dest == src) return i;
        end
        return 3;
    endfunction

    function automatic logic [1:0] sel_of(input int age);
        return (age < 3) ? 2'(age + 1) : 2'd0;
    endfunction

    function automatic logic model_stall();
        int a1;
        int a2;
        if (reset || flush) return 1'b0;
        a1 = age_of(dec_rs, dec_uses_rs);
        a2 = age_of(dec_rt, dec_uses_rt);
        return (a1 == 0 && older[0].is_load) || (a2 == 0 && older[0].is_load);
    endfunction

    always @(posedge clock) begin
        m_entry_t e;
        logic     s;
        if (reset) begin
            older.delete();
            m_sel1      = '0;
            m_sel2      = '0;
            m_valid     = 1'b0;
            m_stall_cnt = '0;
            m_flush_cnt = '0;
            m_ready     = 1'b1;
        end else begin
            s = model_stall();
            m_stall_cnt = m_stall_cnt + {31'd0, s};
            m_flush_cnt = m_flush_cnt + {31'd0, flush};
            if (s || flush) begin
                m_sel1  = '0;
                m_sel2  = '0;
                m_valid = 1'b0;
                e = '{dest: 5'd0, writes: 1'b0, is_load: 1'b0};
            end else begin
                m_sel1  = sel_of(age_of(dec_rs, dec_uses_rs));
                m_sel2  = sel_of(age_of(dec_rt, dec_uses_rt));
                m_valid = 1'b1;
                e = '{dest: dec_dest, writes: dec_writes, is_load: dec_is_load};
            end
            older.push_front(e);
            if (older.size() > 3) void'(older.pop_back());
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clock) begin
        if (m_ready) begin
            check("stall", {31'd0, stall}, {31'd0, model_stall()});
            check("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
            check("ex_fwd_sel_1", {30'd0, ex_fwd_sel_1}, {30'd0, m_sel1});
            check("ex_fwd_sel_2", {30'd0, ex_fwd_sel_2}, {30'd0, m_sel2});
`ifdef PERF_COUNTERS_EN
            check("stall_count", stall_count, m_stall_cnt);
            check("flush_count", flush_count, m_flush_cnt);
`endif
        end
    end

    // ---------------- stimulus ----------------
    logic last_stall;

    // Called at posedge+1; presents one decode instruction for one cycle.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt,
                         input logic [4:0] dest, input logic wr,
                         input logic ld, input logic fl);
        dec_rs      = rs;
        dec_rt      = rt;
        dec_uses_rs = urs;
        dec_uses_rt = urt;
        dec_dest    = dest;
        dec_writes  = wr;
        dec_is_load = ld;
        flush       = fl;
        #3 last_stall = stall;
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        repeat (3) issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        check("reset sel_1", {30'd0, ex_fwd_sel_1}, 32'd0);
        check("reset sel_2", {30'd0, ex_fwd_sel_2}, 32'd0);

        // add r3,r1,r2 ; add r4,r3,r3
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        issue(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        check("back2back stall", {31'd0, last_stall}, 32'd0);
        check("back2back sel_1", {30'd0, ex_fwd_sel_1}, 32'd1);
        check("back2back sel_2", {30'd0, ex_fwd_sel_2}, 32'd1);
        check("back2back valid", {31'd0, ex_valid}, 32'd1);
        drain();

        // producer r5, then 1/2/3 independent instructions, then consumer
        for (int gap = 1; gap <= 3; gap++) begin
            issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
            for (int k = 0; k < gap; k++)
                issue(5'd11, 5'd12, 1'b1, 1'b1, 5'(8 + k), 1'b1, 1'b0, 1'b0);
            issue(5'd5, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
            check($sformatf("gap%0d sel_1", gap), {30'd0, ex_fwd_sel_1},
                  (gap == 1) ? 32'd2 : (gap == 2) ? 32'd3 : 32'd0);
            drain();
        end

        // load r6 ; add r7,r6,r1 -> one stall cycle, then MEM forward
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        issue(5'd6, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        check("load-use stall", {31'd0, last_stall}, 32'd1);
        check("load-use bubble valid", {31'd0, ex_valid}, 32'd0);
        check("load-use bubble sel_1", {30'd0, ex_fwd_sel_1}, 32'd0);
        issue(5'd6, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        check("load-use restall", {31'd0, last_stall}, 32'd0);
        check("load-use sel_1", {30'd0, ex_fwd_sel_1}, 32'd2);
        check("load-use sel_2", {30'd0, ex_fwd_sel_2}, 32'd0);
        check("load-use valid", {31'd0, ex_valid}, 32'd1);
        drain();

        // load with dest r0, then consumer of r0
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0);
        check("r0 stall", {31'd0, last_stall}, 32'd0);
        check("r0 sel_1", {30'd0, ex_fwd_sel_1}, 32'd0);
        check("r0 sel_2", {30'd0, ex_fwd_sel_2}, 32'd0);
        drain();

        // flush during a load-use stall; squashed dest r13 never forwards
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
        issue(5'd12, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b1);
        check("flush stall", {31'd0, last_stall}, 32'd0);
        check("flush valid", {31'd0, ex_valid}, 32'd0);
        issue(5'd13, 5'd12, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0);
        check("post-flush sel_1", {30'd0, ex_fwd_sel_1}, 32'd0);
        check("post-flush sel_2", {30'd0, ex_fwd_sel_2}, 32'd2);
        drain();

        // reset with three producers in flight
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd20, 1'b1, 1'b0, 1'b0);
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd21, 1'b1, 1'b0, 1'b0);
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd22, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("mid-reset valid", {31'd0, ex_valid}, 32'd0);
        check("mid-reset sel_1", {30'd0, ex_fwd_sel_1}, 32'd0);
`ifdef PERF_COUNTERS_EN
        check("mid-reset stall_count", stall_count, 32'd0);
        check("mid-reset flush_count", flush_count, 32'd0);
`endif
        issue(5'd22, 5'd21, 1'b1, 1'b1, 5'd23, 1'b1, 1'b0, 1'b0);
        check("after-reset sel_1", {30'd0, ex_fwd_sel_1}, 32'd0);
        check("after-reset sel_2", {30'd0, ex_fwd_sel_2}, 32'd0);
        check("after-reset valid", {31'd0, ex_valid}, 32'd1);

        // randomized traffic over a small register set to provoke hazards
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        end
        reset = 1'b0;

        #10;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
